// File: rtl/fiao_age_queue_pkg.sv
// rtl/fiao_age_queue_pkg.sv - pointer tag type and pointer arithmetic shared by the age queue.
// Tags hold a slot pointer plus a wrap flag so full and empty can be told apart.
package fiao_age_queue_pkg;

  localparam int TAG_PTR_MAX = 8;

  typedef struct packed {
    logic                   wrap;
    logic [TAG_PTR_MAX-1:0] ptr;
  } tag_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int tag_pos(input tag_t t, input int depth);
    return (t.wrap ? depth : 0) + int'(t.ptr);
  endfunction

  function automatic int tag_slot(input tag_t t, input int n, input int depth);
    return (int'(t.ptr) + n) % depth;
  endfunction

  function automatic tag_t tag_add(input tag_t t, input int n, input int depth);
    tag_t r;
    int   pos;
    pos    = (tag_pos(t, depth) + n) % (2 * depth);
    r.wrap = (pos >= depth);
    r.ptr  = TAG_PTR_MAX'(pos % depth);
    return r;
  endfunction

  function automatic int ptr_dist(input tag_t from, input tag_t to, input int depth);
    return (tag_pos(to, depth) - tag_pos(from, depth) + 2 * depth) % (2 * depth);
  endfunction

endpackage

// File: rtl/fiao_age_queue_sel.sv
// rtl/fiao_age_queue_sel.sv - circular oldest-first multi-pick over the request vector.
// Rotates so head sits at bit 0, peels lowest set bits one per pick, then rotates indices back.
module fiao_age_queue_sel
  import fiao_age_queue_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int SEL_WIDTH = 2,
  parameter int PTRW      = ptr_width(DEPTH)
) (
  input  logic [DEPTH-1:0]               req_i,
  input  logic [PTRW-1:0]                head_i,
  output logic [SEL_WIDTH-1:0]           vld_o,
  output logic [SEL_WIDTH-1:0][PTRW-1:0] ptr_o
);

  logic [DEPTH-1:0] rot;
  logic [DEPTH-1:0] avail;
  logic [PTRW-1:0]  idx;
  logic             found;

  always_comb begin
    rot   = '0;
    vld_o = '0;
    ptr_o = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rot[i] = req_i[PTRW'(i) + head_i];
    end
    avail = rot;
    for (int j = 0; j < SEL_WIDTH; j++) begin
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!found && avail[i]) begin
          found = 1'b1;
          idx   = PTRW'(i);
        end
      end
      if (found) begin
        avail[idx] = 1'b0;
        vld_o[j]   = 1'b1;
        ptr_o[j]   = idx + head_i;
      end
    end
  end

endmodule

// File: rtl/fiao_age_queue.sv
// rtl/fiao_age_queue.sv - fill-in-order, issue-any-order age queue with in-order head retirement.
// Optional registered occupancy count: define FIAO_AGE_QUEUE_OCC_CNT_EN.
module fiao_age_queue
  import fiao_age_queue_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int ENQ_WIDTH    = 2,
  parameter int SEL_WIDTH    = 2,
  parameter int RETIRE_WIDTH = 2,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [ENQ_WIDTH-1:0]                       enq_vld_i,
  input  logic [ENQ_WIDTH-1:0][DATA_WIDTH-1:0]       enq_data_i,
  output logic [ENQ_WIDTH-1:0]                       enq_rdy_o,
  output logic [ENQ_WIDTH-1:0][ptr_width(DEPTH)-1:0] enq_ptr_o,
  input  logic [DEPTH-1:0]                           entry_rdy_i,
  output logic [SEL_WIDTH-1:0]                       sel_vld_o,
  output logic [SEL_WIDTH-1:0][ptr_width(DEPTH)-1:0] sel_ptr_o,
  output logic [SEL_WIDTH-1:0][DATA_WIDTH-1:0]       sel_data_o,
  input  logic [SEL_WIDTH-1:0]                       sel_fire_i,
  input  logic                                       flush_i,
  output logic                                       empty_o,
  output logic                                       full_o,
  output logic [ptr_width(DEPTH):0]                  occ_cnt_o
);

  localparam int PTRW = ptr_width(DEPTH);

  tag_t                  head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      pick_req;
  int                    occupancy, free_slots, lane_k, acc_cnt, retire_cnt;
  logic                  retire_run;

  assign occupancy  = ptr_dist(head_q, tail_q, DEPTH);
  assign free_slots = DEPTH - occupancy;

  // Requesting lanes are packed onto consecutive slots from tail; idle lanes consume nothing.
  always_comb begin
    enq_rdy_o = '0;
    enq_ptr_o = '0;
    lane_k    = 0;
    acc_cnt   = 0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      enq_ptr_o[i] = PTRW'(tag_slot(tail_q, lane_k, DEPTH));
      if (enq_vld_i[i]) begin
        enq_rdy_o[i] = (lane_k < free_slots) && !flush_i && !rst;
        if (enq_rdy_o[i]) acc_cnt = acc_cnt + 1;
        lane_k = lane_k + 1;
      end
    end
  end

  assign pick_req = valid_q & entry_rdy_i & {DEPTH{!rst}};

  fiao_age_queue_sel #(
    .DEPTH    (DEPTH),
    .SEL_WIDTH(SEL_WIDTH),
    .PTRW     (PTRW)
  ) u_sel (
    .req_i (pick_req),
    .head_i(head_q.ptr[PTRW-1:0]),
    .vld_o (sel_vld_o),
    .ptr_o (sel_ptr_o)
  );

  always_comb begin
    for (int j = 0; j < SEL_WIDTH; j++) begin
      sel_data_o[j] = data_q[sel_ptr_o[j]];
    end
  end

  // Retirement only looks at registered valid bits, so a fire is seen one edge later.
  always_comb begin
    retire_cnt = 0;
    retire_run = 1'b1;
    for (int r = 0; r < RETIRE_WIDTH; r++) begin
      if (retire_run && (r < occupancy) && !valid_q[PTRW'(tag_slot(head_q, r, DEPTH))])
        retire_cnt = retire_cnt + 1;
      else
        retire_run = 1'b0;
    end
  end

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      for (int j = 0; j < SEL_WIDTH; j++) begin
        if (sel_fire_i[j] && sel_vld_o[j]) valid_d[sel_ptr_o[j]] = 1'b0;
      end
      for (int i = 0; i < ENQ_WIDTH; i++) begin
        if (enq_rdy_o[i]) valid_d[enq_ptr_o[i]] = 1'b1;
      end
      head_d = tag_add(head_q, retire_cnt, DEPTH);
      tail_d = tag_add(tail_q, acc_cnt, DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      if (enq_rdy_o[i]) data_q[enq_ptr_o[i]] <= enq_data_i[i];
    end
  end

  assign empty_o = rst || (head_q == tail_q);
  assign full_o  = !rst && (head_q.ptr == tail_q.ptr) && (head_q.wrap != tail_q.wrap);

`ifdef FIAO_AGE_QUEUE_OCC_CNT_EN
  logic [PTRW:0] occ_q, occ_d;

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + (PTRW+1)'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occ_cnt_o = rst ? '0 : occ_q;
`else
  assign occ_cnt_o = '0;
`endif

endmodule
